// File: rtl/rs_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_scheduler_if
// Description : Handshake bundle between the reservation-station scheduler
//               and its decode, common-data-bus and ALU neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_scheduler_if #(
    parameter int IDXBW   = 4,
    parameter int ROBIDBW = 4
);
    // Global control
    logic               rdy_in;
    logic               flush;

    // Allocation request / grant
    logic               alloc_req;
    logic               alloc_q1_valid;
    logic [ROBIDBW-1:0] alloc_q1;
    logic               alloc_q2_valid;
    logic [ROBIDBW-1:0] alloc_q2;
    logic               alloc_gnt;
    logic [IDXBW-1:0]   alloc_idx;
    logic               rs_full;
    logic [IDXBW:0]     rs_count;

    // Common data bus broadcasts
    logic               cdb0_valid;
    logic [ROBIDBW-1:0] cdb0_tag;
    logic               cdb1_valid;
    logic [ROBIDBW-1:0] cdb1_tag;

    // Issue offer to the ALU
    logic               issue_valid;
    logic [IDXBW-1:0]   issue_idx;
    logic               issue_ready;

    // Scheduler side
    modport slave (
        input  rdy_in, flush,
        input  alloc_req, alloc_q1_valid, alloc_q1, alloc_q2_valid, alloc_q2,
        input  cdb0_valid, cdb0_tag, cdb1_valid, cdb1_tag,
        input  issue_ready,
        output alloc_gnt, alloc_idx, rs_full, rs_count,
        output issue_valid, issue_idx
    );

    // Pipeline side driving the scheduler
    modport master (
        output rdy_in, flush,
        output alloc_req, alloc_q1_valid, alloc_q1, alloc_q2_valid, alloc_q2,
        output cdb0_valid, cdb0_tag, cdb1_valid, cdb1_tag,
        output issue_ready,
        input  alloc_gnt, alloc_idx, rs_full, rs_count,
        input  issue_valid, issue_idx
    );
endinterface
`default_nettype wire

// File: rtl/rs_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_scheduler
// Description : Reservation-station control core. Tracks slot occupancy and
//               operand tags, allocates the lowest free slot, wakes operands
//               from two CDBs and offers one ready slot per cycle to the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_scheduler #(
    parameter int RSSZ    = 16,
    parameter int IDXBW   = 4,
    parameter int ROBIDBW = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    rs_scheduler_if.slave  bus
);

    localparam logic [IDXBW:0] FULL_COUNT = (IDXBW+1)'(RSSZ);
    localparam logic [IDXBW:0] ONE_COUNT  = (IDXBW+1)'(1);

    // ------------------------------------------------------------------------
    // Slot state
    // ------------------------------------------------------------------------
    logic [RSSZ-1:0]    busy_q, busy_d;
    logic [RSSZ-1:0]    q1v_q,  q1v_d;
    logic [RSSZ-1:0]    q2v_q,  q2v_d;
    logic [ROBIDBW-1:0] q1_q [RSSZ];
    logic [ROBIDBW-1:0] q1_d [RSSZ];
    logic [ROBIDBW-1:0] q2_q [RSSZ];
    logic [ROBIDBW-1:0] q2_d [RSSZ];

    // Offer lock keeps the presented slot stable while the ALU stalls
    logic               lock_q, lock_d;
    logic [IDXBW-1:0]   lock_idx_q, lock_idx_d;

    logic [IDXBW:0]     count_q, count_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [RSSZ-1:0]    ready_w;
    logic               free_found_w;
    logic [IDXBW-1:0]   free_idx_w;
    logic               ready_found_w;
    logic [IDXBW-1:0]   ready_idx_w;
    logic               full_w;
    logic               gnt_w;
    logic               offer_w;
    logic               issue_valid_w;
    logic [IDXBW-1:0]   issue_idx_w;
    logic               issue_fire_w;

    // True when either broadcast carries the given tag this cycle
    function automatic logic cdb_hit(
        input logic [ROBIDBW-1:0] tag,
        input logic               v0,
        input logic [ROBIDBW-1:0] t0,
        input logic               v1,
        input logic [ROBIDBW-1:0] t1
    );
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    // A slot may issue once it is occupied and no operand is still pending
    assign ready_w = busy_q & ~q1v_q & ~q2v_q;

    // Lowest free slot, from registered occupancy only
    always_comb begin
        free_found_w = 1'b0;
        free_idx_w   = '0;
        for (int i = 0; i < RSSZ; i++) begin
            if (!busy_q[i] && !free_found_w) begin
                free_found_w = 1'b1;
                free_idx_w   = IDXBW'(i);
            end
        end
    end

    // Lowest ready slot for a fresh offer
    always_comb begin
        ready_found_w = 1'b0;
        ready_idx_w   = '0;
        for (int i = 0; i < RSSZ; i++) begin
            if (ready_w[i] && !ready_found_w) begin
                ready_found_w = 1'b1;
                ready_idx_w   = IDXBW'(i);
            end
        end
    end

    assign full_w        = (count_q == FULL_COUNT);
    assign gnt_w         = bus.alloc_req && !full_w && bus.rdy_in && !bus.flush;
    assign offer_w       = lock_q || ready_found_w;
    assign issue_valid_w = offer_w && bus.rdy_in && !bus.flush;
    assign issue_idx_w   = lock_q ? lock_idx_q : ready_idx_w;
    assign issue_fire_w  = issue_valid_w && bus.issue_ready;

    assign bus.alloc_gnt   = gnt_w;
    assign bus.alloc_idx   = free_idx_w;
    assign bus.rs_full     = full_w;
    assign bus.rs_count    = count_q;
    assign bus.issue_valid = issue_valid_w;
    assign bus.issue_idx   = issue_idx_w;

    // Next-state: flush dominates; otherwise wakeup, issue and allocate together
    always_comb begin
        busy_d     = busy_q;
        q1v_d      = q1v_q;
        q2v_d      = q2v_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        count_d    = count_q;

        if (bus.rdy_in) begin
            if (bus.flush) begin
                busy_d  = '0;
                q1v_d   = '0;
                q2v_d   = '0;
                lock_d  = 1'b0;
                count_d = '0;
            end else begin
                // Wakeup of pending operands in occupied slots
                for (int i = 0; i < RSSZ; i++) begin
                    if (busy_q[i] && q1v_q[i] &&
                        cdb_hit(q1_q[i], bus.cdb0_valid, bus.cdb0_tag,
                                bus.cdb1_valid, bus.cdb1_tag)) begin
                        q1v_d[i] = 1'b0;
                    end
                    if (busy_q[i] && q2v_q[i] &&
                        cdb_hit(q2_q[i], bus.cdb0_valid, bus.cdb0_tag,
                                bus.cdb1_valid, bus.cdb1_tag)) begin
                        q2v_d[i] = 1'b0;
                    end
                end

                // Issue handshake: release on accept, lock on stall
                if (issue_fire_w) begin
                    busy_d[issue_idx_w] = 1'b0;
                    lock_d              = 1'b0;
                end else if (issue_valid_w) begin
                    lock_d     = 1'b1;
                    lock_idx_d = issue_idx_w;
                end

                // Allocation; an operand produced this very cycle is stored as ready
                if (gnt_w) begin
                    busy_d[free_idx_w] = 1'b1;
                    q1_d[free_idx_w]   = bus.alloc_q1;
                    q2_d[free_idx_w]   = bus.alloc_q2;
                    q1v_d[free_idx_w]  = bus.alloc_q1_valid &&
                        !cdb_hit(bus.alloc_q1, bus.cdb0_valid, bus.cdb0_tag,
                                 bus.cdb1_valid, bus.cdb1_tag);
                    q2v_d[free_idx_w]  = bus.alloc_q2_valid &&
                        !cdb_hit(bus.alloc_q2, bus.cdb0_valid, bus.cdb0_tag,
                                 bus.cdb1_valid, bus.cdb1_tag);
                end

                // Occupancy count; grant and issue together cancel out
                case ({gnt_w, issue_fire_w})
                    2'b10:   count_d = count_q + ONE_COUNT;
                    2'b01:   count_d = count_q - ONE_COUNT;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q     <= '0;
            q1v_q      <= '0;
            q2v_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            count_q    <= '0;
            for (int i = 0; i < RSSZ; i++) begin
                q1_q[i] <= '0;
                q2_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            q1v_q      <= q1v_d;
            q2v_q      <= q2v_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            count_q    <= count_d;
            for (int i = 0; i < RSSZ; i++) begin
                q1_q[i] <= q1_d[i];
                q2_q[i] <= q2_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_scheduler
// Description : Directed, table-driven bench for rs_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_scheduler;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    always #5 clk_in = ~clk_in;

    rs_scheduler_if #(.IDXBW(4), .ROBIDBW(4)) bus ();

    rs_scheduler #(.RSSZ(16), .IDXBW(4), .ROBIDBW(4)) u_dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct {
        logic       rdy;
        logic       flush;
        logic       req;
        logic       q1v;
        logic [3:0] q1;
        logic       q2v;
        logic [3:0] q2;
        logic       c0v;
        logic [3:0] c0t;
        logic       c1v;
        logic [3:0] c1t;
        logic       ir;
        logic       e_gnt;
        logic [3:0] e_idx;
        logic       e_full;
        logic [4:0] e_cnt;
        logic       e_iv;
        logic [3:0] e_iidx;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(
        input int rdy, input int fl, input int req,
        input int q1v, input int q1, input int q2v, input int q2,
        input int c0v, input int c0t, input int c1v, input int c1t, input int ir,
        input int gnt, input int idx, input int full, input int cnt,
        input int iv, input int iidx
    );
        vec_t v;
        v.rdy    = 1'(rdy);
        v.flush  = 1'(fl);
        v.req    = 1'(req);
        v.q1v    = 1'(q1v);
        v.q1     = 4'(q1);
        v.q2v    = 1'(q2v);
        v.q2     = 4'(q2);
        v.c0v    = 1'(c0v);
        v.c0t    = 4'(c0t);
        v.c1v    = 1'(c1v);
        v.c1t    = 4'(c1t);
        v.ir     = 1'(ir);
        v.e_gnt  = 1'(gnt);
        v.e_idx  = 4'(idx);
        v.e_full = 1'(full);
        v.e_cnt  = 5'(cnt);
        v.e_iv   = 1'(iv);
        v.e_iidx = 4'(iidx);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rdy_in         = v.rdy;
        bus.flush          = v.flush;
        bus.alloc_req      = v.req;
        bus.alloc_q1_valid = v.q1v;
        bus.alloc_q1       = v.q1;
        bus.alloc_q2_valid = v.q2v;
        bus.alloc_q2       = v.q2;
        bus.cdb0_valid     = v.c0v;
        bus.cdb0_tag       = v.c0t;
        bus.cdb1_valid     = v.c1v;
        bus.cdb1_tag       = v.c1t;
        bus.issue_ready    = v.ir;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, " alloc_gnt"},   int'(bus.alloc_gnt),   int'(v.e_gnt));
        chk({tag, " alloc_idx"},   int'(bus.alloc_idx),   int'(v.e_idx));
        chk({tag, " rs_full"},     int'(bus.rs_full),     int'(v.e_full));
        chk({tag, " rs_count"},    int'(bus.rs_count),    int'(v.e_cnt));
        chk({tag, " issue_valid"}, int'(bus.issue_valid), int'(v.e_iv));
        chk({tag, " issue_idx"},   int'(bus.issue_idx),   int'(v.e_iidx));
    endtask

    // Drive one cycle, sample at the falling edge, then cross the rising edge
    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        @(negedge clk_in);
        check_outputs(tag, v);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,0,0,0,0,0);

        // -------------------- vector table --------------------
        //          rdy fl req q1v q1 q2v q2 c0v c0t c1v c1t ir | gnt idx full cnt iv iidx
        // Three grants, offer locked on slot 0, then back-to-back issue
        tbl.push_back(mk(1,0,1, 0,0,0,0, 0,0,0,0, 0,  1,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 0,0,0,0, 0,  1,1,0,1,1,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 0,0,0,0, 0,  1,2,0,2,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,3,0,3,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,2,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,1,1,2));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,0,0,0,0,0));
        // Fill all 16 slots waiting on tag 5
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1,0,1, 1,5,0,0, 0,0,0,0, 0,  1,i,0,i,0,0));
        // 17th request refused while full
        tbl.push_back(mk(1,0,1, 1,5,0,0, 0,0,0,0, 0,  0,0,1,16,0,0));
        // Broadcast tag 5: every slot ready the following cycle
        tbl.push_back(mk(1,0,0, 0,0,0,0, 1,5,0,0, 0,  0,0,1,16,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,0,1,16,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,0,1,16,1,0));
        // Drain down to 10 busy slots (6..15)
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,16-k,1,k));
        // Flush with a request and issue_ready: flush wins
        tbl.push_back(mk(1,1,1, 0,0,0,0, 0,0,0,0, 1,  0,0,0,10,0,6));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 0,0,0,0, 0,  1,0,0,0,0,0));
        tbl.push_back(mk(1,1,0, 0,0,0,0, 0,0,0,0, 0,  0,1,0,1,0,0));
        // Slots 0..2 pending (tags 8,9,8), slot 3 ready
        tbl.push_back(mk(1,0,1, 1,8,0,0, 0,0,0,0, 0,  1,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 1,9,0,0, 0,0,0,0, 0,  1,1,0,1,0,0));
        tbl.push_back(mk(1,0,1, 1,8,0,0, 0,0,0,0, 0,  1,2,0,2,0,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 0,0,0,0, 0,  1,3,0,3,0,0));
        // Slot 3 offered and stalled while slot 1 wakes: offer stays on 3
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,1,9, 0,  0,4,0,4,1,3));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,4,0,4,1,3));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,4,0,4,1,3));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,3,0,3,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,3,0,3,1,1));
        // Same-cycle bypass of both operands
        tbl.push_back(mk(1,0,1, 1,7,1,9, 1,7,1,9, 0,  1,1,0,2,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,3,0,3,1,1));
        // rdy_in low with traffic: nothing moves, lock retained
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,0,1, 0,0,0,0, 1,8,0,0, 1,  0,3,0,3,0,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,3,0,3,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,3,0,3,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,1,0,2,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 1,8,0,0, 0,  0,1,0,2,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,1,0,2,1,0));
        // Slot 1 waits on 3 and 4; both CDBs wake it while slot 0 issues and slot 3 allocates
        tbl.push_back(mk(1,0,1, 1,3,1,4, 0,0,0,0, 0,  1,1,0,2,1,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 1,3,1,4, 1,  1,3,0,3,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,3,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,2,1,2));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,1,1,3));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,  0,0,0,0,0,0));

        // -------------------- reset state --------------------
        drive(idle);
        #1;
        check_outputs("reset", idle);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // -------------------- table --------------------
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

        // -------------------- asynchronous reset mid-operation --------------------
        run_vec(mk(1,0,1, 0,0,0,0, 0,0,0,0, 0,  1,0,0,0,0,0), "pre_rst");
        drive(idle);
        #2;
        chk("pre_rst count", int'(bus.rs_count), 1);
        chk("pre_rst issue_valid", int'(bus.issue_valid), 1);
        rst_in = 1'b0;
        #1;
        check_outputs("async_rst", idle);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        run_vec(mk(1,0,0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,0,0,0), "post_rst");
        run_vec(mk(1,0,1, 0,0,0,0, 0,0,0,0, 0,  1,0,0,0,0,0), "post_rst_alloc");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
- Control and scheduling core for the reservation station; holds no operand values or opcodes.
- Tracks per-slot busy state and operand tags, and allocates the lowest free slot to the dispatching instruction.
- Wakes pending operands from two CDB broadcasts (ALU, LSB) and selects one ready slot per cycle for the ALU with a valid/ready handshake.
- The RS data arrays are indexed by alloc_idx (write) and issue_idx (read).

Parameters:
RSSZ, 16, number of RS slots
IDXBW, 4, slot index width, clog2(RSSZ)
ROBIDBW, 4, ROB tag width

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; low freezes all state
flush  in  1  mispredict flush, synchronous
alloc_req  in  1  decoder requests an RS slot
alloc_q1_valid  in  1  operand 1 pending on a ROB tag
alloc_q1  in  ROBIDBW  operand 1 tag
alloc_q2_valid  in  1  operand 2 pending on a ROB tag
alloc_q2  in  ROBIDBW  operand 2 tag
alloc_gnt  out  1  allocation accepted this cycle
alloc_idx  out  IDXBW  slot written on grant
rs_full  out  1  all slots busy (registered state)
rs_count  out  IDXBW+1  number of busy slots
cdb0_valid  in  1  ALU broadcast valid
cdb0_tag  in  ROBIDBW  ALU broadcast tag
cdb1_valid  in  1  LSB broadcast valid
cdb1_tag  in  ROBIDBW  LSB broadcast tag
issue_valid  out  1  a ready slot is offered to the ALU
issue_idx  out  IDXBW  offered slot
issue_ready  in  1  ALU accepts the offer

Behaviour:
- Reset (rst_in=0, asynchronous): all busy, q1v and q2v bits cleared; lock cleared; rs_count=0, rs_full=0, issue_valid=0, alloc_gnt=0, alloc_idx=0, issue_idx=0.
- Per-slot state: busy, q1v, q1, q2v, q2. A slot is ready when busy && !q1v && !q2v.
- Allocation (combinational):
  - alloc_gnt = alloc_req && !rs_full && rdy_in && !flush.
  - alloc_idx = lowest index with busy=0; 0 when full.
  - On grant at the clock edge: busy=1 and the tags are stored.
  - Same-cycle bypass: a q tag equal to a valid cdb0_tag or cdb1_tag this cycle is stored with qv=0.
- A slot freed by issue in cycle N is not allocatable until N+1. rs_full is derived from registered busy only.
- Wakeup: at each edge, every busy slot with qv=1 and q equal to a valid CDB tag clears qv. Both CDBs may match the same slot, or different operands of it, in one cycle.
- Woken slots become issue-eligible the cycle after the broadcast. A newly allocated slot is eligible from the cycle after allocation at the earliest.
- Issue selection:
  - If lock is clear: issue_valid = any ready slot; issue_idx = lowest ready index.
  - If lock is set: issue_valid=1, issue_idx = locked index.
  - issue_valid is forced 0 when rdy_in=0 or flush=1.
- Issue handshake:
  - If issue_valid && !issue_ready, lock is set and holds issue_idx, so the offer stays stable until accepted.
  - If issue_valid && issue_ready, the selected slot's busy is cleared at the edge and lock is cleared.
  - At most one issue per cycle.
- rs_count is updated by +1 on grant, -1 on issue, net 0 when both occur. It never exceeds RSSZ. rs_full = (rs_count == RSSZ).
- Flush: at the edge, all busy, q1v and q2v bits, lock and rs_count are cleared. Flush dominates a same-cycle grant, issue and wakeup.
- rdy_in=0: no state changes, alloc_gnt=0, issue_valid=0. Lock state is retained and resumes when rdy_in returns high.
- Simultaneous allocate, issue and wakeup touching different slots all take effect in the same edge.
- Reset asserted mid-operation overrides everything immediately.

Test Plan:
- Reset, then 3 grants with both operands ready (qv=0) -> alloc_idx 0,1,2; issue_valid the following cycle with issue_idx=0; issue_ready held 1 -> slots 0,1,2 issue on consecutive cycles; rs_count 3->0.
- Fill 16 slots with q1v=1, q1=5 -> rs_full=1, alloc_gnt=0 on a 17th request; cdb0 tag 5 -> all slots ready next cycle; issue_idx=0 is offered first.
- Slot 3 offered with issue_ready=0; slot 1 is then woken -> issue_idx stays 3 until accepted, then 1 is offered.
- Allocate with q1=7 and q2=9 while cdb0=7 and cdb1=9 in the same cycle -> slot is eligible the next cycle (bypass).
- 10 busy slots, flush together with alloc_req and issue_ready -> rs_count=0, no grant, issue_valid=0 the next cycle; next allocation gets idx 0.
- rdy_in=0 for 4 cycles with CDB traffic -> no wakeup, no grant and no issue occur; state is identical when rdy_in rises.
